// File: rtl/cache_cpu_front.sv
// cache_cpu_front
// CPU-side front end of the data cache, directly upstream of the cache controller.
// Takes one word request per transaction, splits the address into {tag, idx, offset},
// holds it stable on the controller interface until hit, then returns a registered
// one-cycle response. Adds alignment checking, a miss watchdog and hit/miss counters.
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   req_valid/write/addr/wdata  CPU request (held by the CPU until req_ready)
//   req_ready                   front is idle and can accept a request
//   resp_valid/rdata/err        one-cycle response; rdata holds until next load hit
//   c_en/write_en/tag/idx/      registered controller request, stable during ACCESS
//   offset/data
//   c_hit, c_out                controller hit (same cycle) and read word
//   stat_clr                    synchronous clear of both counters
//   hit_count, miss_count       saturating performance counters
module cache_cpu_front #(
  parameter int unsigned TAG_WIDTH    = 22,
  parameter int unsigned SET_WIDTH    = 4,
  parameter int unsigned LINE_WIDTH   = 6,
  parameter int unsigned MISS_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  c_en,
  output logic                  c_write_en,
  output logic [TAG_WIDTH-1:0]  c_tag,
  output logic [SET_WIDTH-1:0]  c_idx,
  output logic [LINE_WIDTH-1:0] c_offset,
  output logic [31:0]           c_data,
  input  logic                  c_hit,
  input  logic [31:0]           c_out,
  input  logic                  stat_clr,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  localparam int unsigned WdWidth = $clog2(MISS_TIMEOUT);
  localparam logic [WdWidth-1:0] WdMax = WdWidth'(MISS_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [WdWidth-1:0]   wd_cnt_q, wd_cnt_d;
  logic                 first_q, first_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_err_q, resp_err_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;
  logic [31:0]          hit_count_q, hit_count_d;
  logic [31:0]          miss_count_q, miss_count_d;
  logic                 hit_inc, miss_inc;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wd_cnt_d     = wd_cnt_q;
    first_d      = first_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_addr[1:0] != 2'b00) begin
            // Misaligned: reject without touching the controller.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            write_d  = req_write;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            wd_cnt_d = '0;
            first_d  = 1'b1;
            state_d  = StAccess;
          end
        end
      end
      StAccess: begin
        if (c_hit) begin
          if (!write_q) begin
            resp_rdata_d = c_out;
          end
          resp_valid_d = 1'b1;
          state_d      = StIdle;
          hit_inc      = first_q;
          miss_inc     = !first_q;
        end else begin
          first_d  = 1'b0;
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (wd_cnt_q == WdMax) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counters saturate; a clear in the same cycle as an increment wins.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (stat_clr) begin
      hit_count_d  = '0;
      miss_count_d = '0;
    end else begin
      if (hit_inc && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_d = hit_count_q + 32'd1;
      end
      if (miss_inc && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wd_cnt_q     <= '0;
      first_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wd_cnt_q     <= wd_cnt_d;
      first_q      <= first_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Controller request fields come straight from the latched request registers.
  assign req_ready  = (state_q == StIdle);
  assign c_en       = (state_q == StAccess);
  assign c_write_en = write_q;
  assign c_data     = wdata_q;
  assign c_tag      = addr_q[31 -: TAG_WIDTH];
  assign c_idx      = addr_q[LINE_WIDTH +: SET_WIDTH];
  assign c_offset   = addr_q[LINE_WIDTH-1:0];
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_cpu_front.sv
module tb_cache_cpu_front;

  localparam int unsigned TW = 22;
  localparam int unsigned SW = 4;
  localparam int unsigned LW = 6;
  localparam int unsigned TO = 24;
  localparam int N = 60;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          c_en;
  logic          c_write_en;
  logic [TW-1:0] c_tag;
  logic [SW-1:0] c_idx;
  logic [LW-1:0] c_offset;
  logic [31:0]   c_data;
  logic          c_hit = 1'b0;
  logic [31:0]   c_out = '0;
  logic          stat_clr = 1'b0;
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;

  cache_cpu_front #(
    .TAG_WIDTH   (TW),
    .SET_WIDTH   (SW),
    .LINE_WIDTH  (LW),
    .MISS_TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .c_en      (c_en),
    .c_write_en(c_write_en),
    .c_tag     (c_tag),
    .c_idx     (c_idx),
    .c_offset  (c_offset),
    .c_data    (c_data),
    .c_hit     (c_hit),
    .c_out     (c_out),
    .stat_clr  (stat_clr),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [31:0] m_rdata = '0;
  logic [31:0] m_hits = '0;
  logic [31:0] m_misses = '0;

  // Transaction table
  logic        t_wr[N];
  logic [31:0] t_addr[N];
  logic [31:0] t_wd[N];
  logic [31:0] t_cout[N];
  int          t_lat[N];  // ACCESS cycles of miss before hit; >= TO means never hits
  int          t_gap[N];  // idle cycles before this request; 0 = held back-to-back
  logic        t_clr[N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic present(input int j);
    req_valid = 1'b1;
    req_write = t_wr[j];
    req_addr  = t_addr[j];
    req_wdata = t_wd[j];
  endtask

  task automatic run_txn(input int i);
    bit hold;
    bit done;
    int k;
    int gap;
    logic [31:0] a;
    hold = (i + 1 < N) && (t_gap[i+1] == 0);
    gap  = (i + 1 < N) ? t_gap[i+1] : 1;
    a    = t_addr[i];
    present(i);
    check_val("ready_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (a[1:0] != 2'b00) begin
      if (hold) present(i + 1); else req_valid = 1'b0;
      check_val("misal_valid", 32'(resp_valid), 32'd1);
      check_val("misal_err", 32'(resp_err), 32'd1);
      check_val("misal_c_en", 32'(c_en), 32'd0);
      check_val("misal_hits", hit_count, m_hits);
      check_val("misal_misses", miss_count, m_misses);
    end else begin
      k = 0;
      done = 0;
      while (!done) begin
        if (hold) present(i + 1); else req_valid = 1'b0;
        check_val("acc_c_en", 32'(c_en), 32'd1);
        check_val("acc_ready", 32'(req_ready), 32'd0);
        check_val("acc_resp_valid", 32'(resp_valid), 32'd0);
        check_val("acc_tag", 32'(c_tag), a >> (SW + LW));
        check_val("acc_idx", 32'(c_idx), (a >> LW) % (32'd1 << SW));
        check_val("acc_off", 32'(c_offset), a % (32'd1 << LW));
        check_val("acc_we", 32'(c_write_en), 32'(t_wr[i]));
        check_val("acc_data", c_data, t_wd[i]);
        c_hit    = (k == t_lat[i]);
        c_out    = t_cout[i];
        stat_clr = c_hit && t_clr[i];
        @(posedge clk);
        if (c_hit) begin
          if (t_clr[i]) begin
            m_hits = 0;
            m_misses = 0;
          end else if (k == 0) m_hits++;
          else m_misses++;
          if (!t_wr[i]) m_rdata = t_cout[i];
        end
        @(negedge clk);
        c_hit = 1'b0;
        stat_clr = 1'b0;
        done = (k == t_lat[i]) || (k == TO - 1);
        k++;
      end
      check_val("resp_valid", 32'(resp_valid), 32'd1);
      check_val("resp_err", 32'(resp_err), 32'(t_lat[i] >= TO));
      check_val("resp_rdata", resp_rdata, m_rdata);
      check_val("hit_count", hit_count, m_hits);
      check_val("miss_count", miss_count, m_misses);
      check_val("resp_c_en", 32'(c_en), 32'd0);
      check_val("resp_ready", 32'(req_ready), 32'd1);
    end
    if (!hold) begin
      req_valid = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        @(negedge clk);
        check_val("idle_resp_valid", 32'(resp_valid), 32'd0);
      end
    end
  endtask

  task automatic reset_mid_access();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0000_3100;
    req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("rst_pre_c_en", 32'(c_en), 32'd1);
    reset = 1'b0;
    #1;
    m_hits = 0;
    m_misses = 0;
    m_rdata = 0;
    check_val("rst_ready", 32'(req_ready), 32'd1);
    check_val("rst_c_en", 32'(c_en), 32'd0);
    check_val("rst_hits", hit_count, m_hits);
    check_val("rst_misses", miss_count, m_misses);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_post_valid", 32'(resp_valid), 32'd0);
    check_val("rst_post_c_en", 32'(c_en), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    // Directed entries
    t_wr[0] = 0; t_addr[0] = 32'h0000_1044; t_wd[0] = 0; t_lat[0] = 0;
    t_cout[0] = 32'hCAFE_0001; t_gap[0] = 1; t_clr[0] = 0;
    t_wr[1] = 1; t_addr[1] = 32'hA5A5_0080; t_wd[1] = 32'h1234_5678; t_lat[1] = 20;
    t_cout[1] = 32'hDEAD_BEEF; t_gap[1] = 1; t_clr[1] = 0;
    t_wr[2] = 0; t_addr[2] = 32'h0000_0002; t_wd[2] = 0; t_lat[2] = 0;
    t_cout[2] = 0; t_gap[2] = 2; t_clr[2] = 0;
    t_wr[3] = 0; t_addr[3] = 32'h0000_0400; t_wd[3] = 0; t_lat[3] = 999;
    t_cout[3] = 32'h1111_1111; t_gap[3] = 1; t_clr[3] = 0;
    t_wr[4] = 0; t_addr[4] = 32'hFFFF_FFFC; t_wd[4] = 0; t_lat[4] = TO - 1;
    t_cout[4] = 32'h2222_2222; t_gap[4] = 1; t_clr[4] = 0;
    t_wr[5] = 0; t_addr[5] = 32'h0000_0010; t_wd[5] = 0; t_lat[5] = 0;
    t_cout[5] = 32'h3333_3333; t_gap[5] = 1; t_clr[5] = 0;
    t_wr[6] = 0; t_addr[6] = 32'h0000_0020; t_wd[6] = 0; t_lat[6] = 0;
    t_cout[6] = 32'h4444_4444; t_gap[6] = 0; t_clr[6] = 1;
    // Random entries
    for (int i = 7; i < N; i++) begin
      t_wr[i] = 1'($urandom_range(0, 1));
      r = $urandom;
      if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(1, 3));
      else r[1:0] = 2'b00;
      t_addr[i] = r;
      t_wd[i]   = $urandom;
      t_cout[i] = $urandom;
      t_lat[i]  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, TO + 2));
      t_gap[i]  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      t_clr[i]  = ($urandom_range(0, 7) == 0);
    end
    t_gap[7] = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("reset_ready", 32'(req_ready), 32'd1);
    check_val("reset_valid", 32'(resp_valid), 32'd0);
    check_val("reset_err", 32'(resp_err), 32'd0);
    check_val("reset_c_en", 32'(c_en), 32'd0);
    check_val("reset_tag", 32'(c_tag), 32'd0);
    check_val("reset_rdata", resp_rdata, 32'd0);
    check_val("reset_hits", hit_count, 32'd0);
    check_val("reset_misses", miss_count, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < N; i++) begin
      if (i == 7) reset_mid_access();
      run_txn(i);
      if (i == 0) begin
        check_val("t0_hits_const", hit_count, 32'd1);
        check_val("t0_rdata_const", resp_rdata, 32'hCAFE_0001);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
